// File: rtl/regshift_pkg.sv
// Shared types and constants for the pipelined register-controlled shifter.
package regshift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    AMT_ZERO,
    AMT_LT,
    AMT_EQ,
    AMT_GT
  } amt_class_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic amt_class_e classify_amt(input logic [7:0] amt, input int unsigned width);
    if (amt == 8'd0) begin
      return AMT_ZERO;
    end else if (32'(amt) < width) begin
      return AMT_LT;
    end else if (32'(amt) == width) begin
      return AMT_EQ;
    end else begin
      return AMT_GT;
    end
  endfunction

endpackage

// File: rtl/regshift_pipe_layer.sv
// One barrel layer: optionally shifts/rotates by SHIFT and captures the last bit shifted out.
module shift_layer
  import regshift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic             en,
  input  shift_op_e        op,
  input  logic [WIDTH-1:0] d,
  input  logic             c_in,
  output logic [WIDTH-1:0] d_out,
  output logic             c_out
);

  always_comb begin
    d_out = d;
    c_out = c_in;
    if (en) begin
      unique case (op)
        SH_LSL: begin
          d_out = d << SHIFT;
          c_out = d[WIDTH-SHIFT];
        end
        SH_LSR: begin
          d_out = d >> SHIFT;
          c_out = d[SHIFT-1];
        end
        SH_ASR: begin
          d_out = $unsigned($signed(d) >>> SHIFT);
          c_out = d[SHIFT-1];
        end
        default: begin
          d_out = {d[SHIFT-1:0], d[WIDTH-1:SHIFT]};
          c_out = d[SHIFT-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/regshift_pipe.sv
// Pipelined register-controlled shifter with valid/ready handshake.
// Optional RRX on ROR selected by defining REGSHIFT_RRX_EN.
module regshift_pipe
  import regshift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       shift_control,
  input  logic [7:0]       rs_amt,
  input  logic [WIDTH-1:0] rm,
  input  logic             carry_in,
`ifdef REGSHIFT_RRX_EN
  input  logic             rrx,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic [3:0]       flags
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int BASE  = LOG_W / PIPE_STAGES;
  localparam int FIRST = BASE + (LOG_W % PIPE_STAGES);

  logic [PIPE_STAGES-1:0] valid_reg;
  logic [PIPE_STAGES-1:0] advance;
  logic [PIPE_STAGES-1:0] src_valid;
  logic [PIPE_STAGES-1:0] carry_reg;
  logic [PIPE_STAGES-1:0] src_carry;
  logic [PIPE_STAGES-1:0] stage_carry;
  logic [WIDTH-1:0]       data_reg   [PIPE_STAGES];
  logic [WIDTH-1:0]       src_data   [PIPE_STAGES];
  logic [WIDTH-1:0]       stage_data [PIPE_STAGES];
  logic [LOG_W-1:0]       amt_reg    [PIPE_STAGES];
  logic [LOG_W-1:0]       src_amt    [PIPE_STAGES];
  shift_op_e              op_reg     [PIPE_STAGES];
  shift_op_e              src_op     [PIPE_STAGES];

  logic [WIDTH-1:0] layer_in  [LOG_W];
  logic [WIDTH-1:0] layer_out [LOG_W];
  logic [LOG_W-1:0] layer_cin;
  logic [LOG_W-1:0] layer_cout;

  logic [3:0]       flags_reg;
  logic [3:0]       flags_next;

  shift_op_e        dec_op;
  amt_class_e       dec_class;
  logic [WIDTH-1:0] dec_data;
  logic             dec_carry;
  logic [LOG_W-1:0] dec_amt;

  // Out-of-range amounts are resolved here so the barrel layers only ever see m = a mod W.
  always_comb begin
    dec_op    = shift_op_e'(shift_control);
    dec_class = classify_amt(rs_amt, WIDTH);
    dec_data  = rm;
    dec_carry = carry_in;
    dec_amt   = rs_amt[LOG_W-1:0];
    unique case (dec_op)
      SH_LSL, SH_LSR: begin
        unique case (dec_class)
          AMT_ZERO: dec_amt = '0;
          AMT_EQ: begin
            dec_data  = '0;
            dec_carry = (dec_op == SH_LSL) ? rm[0] : rm[WIDTH-1];
            dec_amt   = '0;
          end
          AMT_GT: begin
            dec_data  = '0;
            dec_carry = 1'b0;
            dec_amt   = '0;
          end
          default: ;
        endcase
      end
      SH_ASR: begin
        unique case (dec_class)
          AMT_ZERO: dec_amt = '0;
          AMT_EQ, AMT_GT: begin
            dec_data  = {WIDTH{rm[WIDTH-1]}};
            dec_carry = rm[WIDTH-1];
            dec_amt   = '0;
          end
          default: ;
        endcase
      end
      default: begin
        if (dec_class == AMT_ZERO) begin
          dec_amt = '0;
        end else begin
          // Seeds the carry for a multiple-of-W rotate, which enables no layer.
          dec_carry = rm[WIDTH-1];
        end
`ifdef REGSHIFT_RRX_EN
        if (rrx) begin
          dec_data  = {carry_in, rm[WIDTH-1:1]};
          dec_carry = rm[0];
          dec_amt   = '0;
        end
`endif
      end
    endcase
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      localparam int LO  = (gi == 0) ? 0 : FIRST + (gi - 1) * BASE;
      localparam int CNT = (gi == 0) ? FIRST : BASE;

      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid & in_ready;
        assign src_data[gi]  = dec_data;
        assign src_carry[gi] = dec_carry;
        assign src_amt[gi]   = dec_amt;
        assign src_op[gi]    = dec_op;
      end else begin : g_src_reg
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
        assign src_carry[gi] = carry_reg[gi-1];
        assign src_amt[gi]   = amt_reg[gi-1];
        assign src_op[gi]    = op_reg[gi-1];
      end

      // A stage moves when any stage from here to the output has a hole, or the consumer takes.
      assign advance[gi] = out_ready | ~(&valid_reg[PIPE_STAGES-1:gi]);

      for (gj = 0; gj < CNT; gj++) begin : g_layer
        if (gj == 0) begin : g_first
          assign layer_in[LO]  = src_data[gi];
          assign layer_cin[LO] = src_carry[gi];
        end else begin : g_chain
          assign layer_in[LO+gj]  = layer_out[LO+gj-1];
          assign layer_cin[LO+gj] = layer_cout[LO+gj-1];
        end
        shift_layer #(
          .WIDTH(WIDTH),
          .SHIFT(1 << (LO + gj))
        ) u_layer (
          .en   (src_amt[gi][LO+gj]),
          .op   (src_op[gi]),
          .d    (layer_in[LO+gj]),
          .c_in (layer_cin[LO+gj]),
          .d_out(layer_out[LO+gj]),
          .c_out(layer_cout[LO+gj])
        );
      end

      assign stage_data[gi]  = layer_out[LO+CNT-1];
      assign stage_carry[gi] = layer_cout[LO+CNT-1];
    end
  endgenerate

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_N] = stage_data[PIPE_STAGES-1][WIDTH-1];
    flags_next[FLAG_Z] = ~|stage_data[PIPE_STAGES-1];
    flags_next[FLAG_C] = stage_carry[PIPE_STAGES-1];
    flags_next[FLAG_V] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      carry_reg <= '0;
      flags_reg <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_reg[k] <= '0;
        amt_reg[k]  <= '0;
        op_reg[k]   <= SH_LSL;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (advance[k]) begin
          valid_reg[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_reg[k]  <= stage_data[k];
            carry_reg[k] <= stage_carry[k];
            amt_reg[k]   <= src_amt[k];
            op_reg[k]    <= src_op[k];
          end
        end
      end
      if (advance[PIPE_STAGES-1] && src_valid[PIPE_STAGES-1]) begin
        flags_reg <= flags_next;
      end
    end
  end

  assign in_ready  = ~reset & advance[0];
  assign out_valid = valid_reg[PIPE_STAGES-1];
  assign rd        = data_reg[PIPE_STAGES-1];
  assign flags     = flags_reg;

endmodule

// File: tb/tb_regshift_pipe.sv
// Directed bench for regshift_pipe: one DUT per depth (2, 1, 5) sharing the input beat.
module tb_regshift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  shift_control;
  logic [7:0]  rs_amt;
  logic [31:0] rm;
  logic        carry_in;
  logic        rrx;
  logic        out_ready_main;

  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [31:0] rd_o [3];
  logic [3:0]  fl_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regshift_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .shift_control(shift_control), .rs_amt(rs_amt), .rm(rm), .carry_in(carry_in),
`ifdef REGSHIFT_RRX_EN
    .rrx(rrx),
`endif
    .out_valid(ov[0]), .out_ready(out_ready_main), .rd(rd_o[0]), .flags(fl_o[0])
  );

  regshift_pipe #(.WIDTH(32), .PIPE_STAGES(1)) u_dut_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .shift_control(shift_control), .rs_amt(rs_amt), .rm(rm), .carry_in(carry_in),
`ifdef REGSHIFT_RRX_EN
    .rrx(rrx),
`endif
    .out_valid(ov[1]), .out_ready(1'b1), .rd(rd_o[1]), .flags(fl_o[1])
  );

  regshift_pipe #(.WIDTH(32), .PIPE_STAGES(5)) u_dut_p5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .shift_control(shift_control), .rs_amt(rs_amt), .rm(rm), .carry_in(carry_in),
`ifdef REGSHIFT_RRX_EN
    .rrx(rrx),
`endif
    .out_valid(ov[2]), .out_ready(1'b1), .rd(rd_o[2]), .flags(fl_o[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ps_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  // Send one beat into all three DUTs and check each at its own latency.
  task automatic run_single(input string name, input logic [1:0] op, input logic [7:0] amt,
                            input logic [31:0] opnd, input logic cin, input logic r,
                            input logic [31:0] exp_rd, input logic [3:0] exp_fl);
    @(negedge clk);
    shift_control = op;
    rs_amt        = amt;
    rm            = opnd;
    carry_in      = cin;
    rrx           = r;
    in_valid      = 1'b1;
    #1;
    check_eq({name, "_in_ready"}, 64'(ir), 64'(3'b111));
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (c == ps_of(d)) begin
          check_eq($sformatf("%s_p%0d_valid", name, ps_of(d)), 64'(ov[d]), 64'(1'b1));
          check_eq($sformatf("%s_p%0d_rd", name, ps_of(d)), 64'(rd_o[d]), 64'(exp_rd));
          check_eq($sformatf("%s_p%0d_flags", name, ps_of(d)), 64'(fl_o[d]), 64'(exp_fl));
        end else if (c < ps_of(d)) begin
          check_eq($sformatf("%s_p%0d_early", name, ps_of(d)), 64'(ov[d]), 64'(1'b0));
        end
      end
    end
    $display("[TB] %s op=%0d amt=%0d rm=0x%08h cin=%0b rrx=%0b -> rd=0x%08h flags=%04b (exp 0x%08h %04b)",
             name, op, amt, opnd, cin, r, rd_o[0], fl_o[0], exp_rd, exp_fl);
  endtask

  logic [1:0]  b_op  [6];
  logic [7:0]  b_amt [6];
  logic [31:0] b_rm  [6];
  logic        b_cin [6];
  logic [31:0] b_rd  [6];
  logic [3:0]  b_fl  [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int retired;
    logic acc;
    logic ret;

    reset          = 1'b1;
    in_valid       = 1'b0;
    shift_control  = 2'b00;
    rs_amt         = 8'd0;
    rm             = 32'h0;
    carry_in       = 1'b0;
    rrx            = 1'b0;
    out_ready_main = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_in_ready", 64'(ir), 64'(3'b000));
    check_eq("reset_out_valid", 64'(ov), 64'(3'b000));
    check_eq("reset_rd", 64'(rd_o[0]), 64'h0);
    check_eq("reset_flags", 64'(fl_o[0]), 64'h0);
    reset = 1'b0;

    run_single("lsl1",    2'b00, 8'd1,   32'h8000_0001, 1'b0, 1'b0, 32'h0000_0002, 4'b0010);
    run_single("lsr32",   2'b01, 8'd32,  32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
    run_single("lsr33",   2'b01, 8'd33,  32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0100);
    run_single("asr40",   2'b10, 8'd40,  32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1010);
    run_single("asr0",    2'b10, 8'd0,   32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 4'b1010);
    run_single("ror33",   2'b11, 8'd33,  32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b1010);
    run_single("ror32",   2'b11, 8'd32,  32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001, 4'b0000);
    run_single("ror8",    2'b11, 8'd8,   32'h1234_5678, 1'b0, 1'b0, 32'h7812_3456, 4'b0000);
    run_single("lsl32",   2'b00, 8'd32,  32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
    run_single("lsl255",  2'b00, 8'd255, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 4'b0100);
    run_single("lsr5",    2'b01, 8'd5,   32'h8000_0000, 1'b1, 1'b0, 32'h0400_0000, 4'b0000);
    run_single("asr31",   2'b10, 8'd31,  32'h4000_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0110);
`ifdef REGSHIFT_RRX_EN
    run_single("rrx",     2'b11, 8'd5,   32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 4'b1010);
    run_single("rrx_lsl", 2'b00, 8'd4,   32'h0000_0001, 1'b1, 1'b1, 32'h0000_0010, 4'b0000);
`endif

    // Six back-to-back beats against a consumer that stalls for the first four cycles.
    b_op  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    b_amt = '{8'd4, 8'd1, 8'd4, 8'd1, 8'd31, 8'd0};
    b_rm  = '{32'h0000_00F0, 32'h0000_00F1, 32'hF000_0000, 32'h0000_0003, 32'hFFFF_FFFF, 32'h1234_5678};
    b_cin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    b_rd  = '{32'h0000_0F00, 32'h0000_0078, 32'hFF00_0000, 32'h8000_0001, 32'h8000_0000, 32'h1234_5678};
    b_fl  = '{4'b0000, 4'b0010, 4'b1000, 4'b1010, 4'b1010, 4'b0010};
    sent    = 0;
    retired = 0;
    for (int cyc = 0; cyc < 40 && retired < 6; cyc++) begin
      @(negedge clk);
      out_ready_main = (cyc >= 4);
      in_valid       = (sent < 6);
      if (sent < 6) begin
        shift_control = b_op[sent];
        rs_amt        = b_amt[sent];
        rm            = b_rm[sent];
        carry_in      = b_cin[sent];
        rrx           = 1'b0;
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        check_eq($sformatf("stall_in_ready_c%0d", cyc), 64'(ir[0]), 64'(1'b0));
      end
      if (ov[0] && !out_ready_main) begin
        check_eq($sformatf("stall_hold_rd_c%0d", cyc), 64'(rd_o[0]), 64'(b_rd[retired]));
        check_eq($sformatf("stall_hold_flags_c%0d", cyc), 64'(fl_o[0]), 64'(b_fl[retired]));
      end
      acc = in_valid & ir[0];
      ret = ov[0] & out_ready_main;
      if (ret) begin
        check_eq($sformatf("order_rd_%0d", retired), 64'(rd_o[0]), 64'(b_rd[retired]));
        check_eq($sformatf("order_flags_%0d", retired), 64'(fl_o[0]), 64'(b_fl[retired]));
        $display("[TB] retire beat %0d at cycle %0d rd=0x%08h flags=%04b (exp 0x%08h %04b)",
                 retired, cyc, rd_o[0], fl_o[0], b_rd[retired], b_fl[retired]);
        retired++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check_eq("stall_all_retired", 64'(retired), 64'd6);
    out_ready_main = 1'b1;
    repeat (8) @(posedge clk);

    // Two beats in flight, then a one-cycle reset must flush every depth.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      shift_control = 2'b00;
      rs_amt        = 8'(i + 1);
      rm            = 32'h0000_0101;
      carry_in      = 1'b0;
      in_valid      = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(ir), 64'(3'b000));
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("flush_out_valid", 64'(ov), 64'(3'b000));
    check_eq("flush_rd", 64'(rd_o[0]), 64'h0);
    check_eq("flush_flags", 64'(fl_o[0]), 64'h0);
    $display("[TB] reset flush with two beats in flight: out_valid=%03b", ov);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq($sformatf("flush_stale_c%0d", c), 64'(ov), 64'(3'b000));
    end

    run_single("post_rst", 2'b01, 8'd4, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0010, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
